// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
// Operand width and the nibble type used by the adder ports.
package alu_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] nibble_t;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// Single-bit full adder, the ripple-chain cell of the ALU adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ c_in;
    assign c_out    = (a & b) | (c_in & half_sum);

endmodule : full_adder

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// The chain is built from full_adder cells so it can be reused for wider adders.
module four_bit_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  nibble_t a,
    input  nibble_t b,
    input  logic    c_in,
    output nibble_t sum,
    output logic    c_out,
    output logic    overflow
);

    if (WIDTH != 4) begin : g_width_check
        $error("four_bit_adder: only WIDTH=4 is supported");
    end

    // c[i] is the carry into bit i; c[ADDER_WIDTH] is the carry out of the MSB.
    logic [ADDER_WIDTH:0]   c;
    nibble_t                sum_next;
    logic                   overflow_next;

    assign c[0] = c_in;

    for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (c[i]),
            .s     (sum_next[i]),
            .c_out (c[i+1])
        );
    end

    // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
    assign overflow_next = c[ADDER_WIDTH-1] ^ c[ADDER_WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= sum_next;
            c_out    <= c[ADDER_WIDTH];
            overflow <= overflow_next;
        end
    end

endmodule : four_bit_adder

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: the driver queues expected results, a monitor compares them.
module tb_four_bit_adder;
    import alu_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    nibble_t a = '0;
    nibble_t b = '0;
    logic    c_in = 1'b0;
    nibble_t sum;
    logic    c_out;
    logic    overflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] resp;   // {sum, c_out, overflow}
        string      name;
    } exp_t;

    exp_t exp_q[$];

    four_bit_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, unsigned for sum/carry and signed range for overflow.
    function automatic logic [5:0] ref_model(input logic r, input logic [3:0] x,
                                             input logic [3:0] y, input logic ci);
        int u;
        int sx;
        int sy;
        int s;
        logic [4:0] t;
        logic ov;
        if (!r) return 6'b0;
        u  = int'(x) + int'(y) + int'(ci);
        sx = x[3] ? int'(x) - 16 : int'(x);
        sy = y[3] ? int'(y) - 16 : int'(y);
        s  = sx + sy + int'(ci);
        ov = (s > 7) || (s < -8);
        t  = u[4:0];
        return {t[3:0], t[4], ov};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus away from the capturing edge and queue its expected result.
    task automatic drive(input string name, input logic r, input logic [3:0] x,
                         input logic [3:0] y, input logic ci);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        a     = x;
        b     = y;
        c_in  = ci;
        e.resp = ref_model(r, x, y, ci);
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: one registered result per edge for every queued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, {sum, c_out, overflow}, e.resp);
            end
        end
    end

    initial begin
        // Reset held for two edges with arbitrary operands.
        drive("reset0", 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        drive("reset1", 1'b0, 4'hF, 4'hF, 1'b1);

        // Directed mixed-sign, max and min cases; first one is the first result after release.
        drive("8+7+0", 1'b1, 4'h8, 4'h7, 1'b0);
        drive("3+A+1", 1'b1, 4'h3, 4'hA, 1'b1);
        drive("7+2+1", 1'b1, 4'h7, 4'h2, 1'b1);
        drive("F+F+1", 1'b1, 4'hF, 4'hF, 1'b1);
        drive("F+F+0", 1'b1, 4'hF, 4'hF, 1'b0);
        drive("8+8+0", 1'b1, 4'h8, 4'h8, 1'b0);
        drive("8+8+1", 1'b1, 4'h8, 4'h8, 1'b1);

        // Back-to-back random operands with a reset pulse in the middle of the stream.
        for (int i = 0; i < 40; i++) begin
            drive((i == 20) ? "b2b_reset" : "b2b", (i != 20),
                  4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Exhaustive sweep in a shuffled order so consecutive operands are unrelated.
        begin
            int order[512];
            for (int i = 0; i < 512; i++) order[i] = i;
            for (int i = 511; i > 0; i--) begin
                int j;
                int tmp;
                j = int'($urandom_range(i, 0));
                tmp = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            for (int i = 0; i < 512; i++) begin
                logic [8:0] v;
                v = 9'(order[i]);
                drive("exhaustive", 1'b1, v[8:5], v[4:1], v[0]);
            end
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(negedge clk);
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_four_bit_adder
